text_console_ctrl: RTL and testbench
====================================

TEXT_CONSOLE_CTRL -- requirements
Module: text_console_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 80, meaning characters per text row.
REQ-002 SHALL have parameter ROWS, default 60, meaning text rows per screen.
REQ-003 SHALL have parameter BLANK, default 7'h20, meaning the fill code used for clear and erase.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port clr  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port ch_valid  input  1  an ASCII code is offered.
REQ-007 SHALL have port ch_data  input  7  the offered ASCII code.
REQ-008 SHALL have port ch_ready  output  1  the controller accepts ch_data this cycle.
REQ-009 SHALL have port vga_req  input  1  the display reader needs the char RAM port this cycle.
REQ-010 SHALL have port vga_row  input  6  the display read row.
REQ-011 SHALL have port vga_col  input  7  the display read column.
REQ-012 SHALL have port cram_a  output  13  char RAM address {row,col}.
REQ-013 SHALL have port cram_di  output  7  char RAM write data.
REQ-014 SHALL have port cram_we  output  1  char RAM write enable.
REQ-015 SHALL have port cur_row  output  6  the cursor row.
REQ-016 SHALL have port cur_col  output  7  the cursor column.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-018 SHALL use states CLEAR (full-screen sweep), IDLE, WRITE (pending cell write) and CLRLINE (blank the new row).
REQ-019 Port arbitration SHALL be combinational with the display winning: when vga_req=1, cram_a={vga_row,vga_col} and cram_we=0; otherwise cram_a is the controller address.
REQ-020 Any controller write (CLEAR, WRITE, CLRLINE) SHALL stall without advancing while vga_req=1 and SHALL complete in the first cycle in which vga_req=0.
REQ-021 ch_ready SHALL be 1 only in IDLE; a transfer occurs on a rising edge with ch_valid and ch_ready both high.
REQ-022 In CLEAR, the controller SHALL write BLANK to every cell, row-major from (0,0) to (ROWS-1,COLS-1), one cell per unstalled cycle, then enter IDLE with the cursor at (0,0).
REQ-023 A printable code (0x20..0x7E) SHALL enter WRITE; the write puts ch_data at (cur_row,cur_col) one cycle after acceptance if vga_req=0.
REQ-024 After a printable write, the column SHALL increment; from COLS-1 it SHALL wrap to 0 and advance the row, entering CLRLINE.
REQ-025 Code 0x0D SHALL set the column to 0, advance the row and enter CLRLINE, with no write at the old position.
REQ-026 Row advance SHALL increment the row, wrapping from ROWS-1 to 0.
REQ-027 CLRLINE SHALL write BLANK to columns 0..COLS-1 of the new cursor row, then return to IDLE.
REQ-028 Code 0x08 (backspace) SHALL behave by position:
- col>0: decrement the column, then write BLANK at the new position via WRITE.
- col=0 and row>0: move to (row-1,COLS-1) and write BLANK there.
- at (0,0): no move, no write; the code is consumed and the controller stays in IDLE.
REQ-029 Any other code (<0x20 except 0x08 and 0x0D, or 0x7F) SHALL be consumed with no write and no cursor change; the controller stays in IDLE.
REQ-030 cur_row and cur_col SHALL change only on the edge that completes the associated write or control action.

Reset
REQ-031 While clr=1, outputs SHALL be: state CLEAR, cursor (0,0), sweep counter 0, ch_ready=0, busy=1, cram_we=0.
REQ-032 Asserting clr mid-operation SHALL abort the pending write or line clear and restart the full CLEAR sweep from (0,0) after clr falls.

Structure
REQ-033 Package text_pkg SHALL hold COLS/ROWS defaults, BLANK, the codes 0x08 and 0x0D, and the state enumeration.
REQ-034 The row/column counter (increment-with-wrap, decrement, newline) SHALL be sub-module text_cursor; arbitration and the FSM SHALL stay in text_console_ctrl.

Verification
REQ-035 Bench SHALL cover: release clr with vga_req=0 -> 4800 writes of 0x20 from address 0 to {59,79}; then busy=0, ch_ready=1.
REQ-036 Bench SHALL cover: send 0x41 at (0,0) while vga_req toggles 1,1,0 -> cram_we rises on the third cycle only; cell (0,0)=0x41; cursor becomes (0,1).
REQ-037 Bench SHALL cover: at (5,79) send 0x42 -> (5,79)=0x42; cursor (6,0); 80 BLANK writes to row 6.
REQ-038 Bench SHALL cover: at (59,10) send 0x0D -> cursor (0,0); row 0 fully blanked; no write at (59,10).
REQ-039 Bench SHALL cover backspace:
- at (3,0) -> cursor (2,79) and (2,79)=0x20.
- at (0,0) -> no cram_we and cursor unchanged.
REQ-040 Bench SHALL cover: assert clr during CLRLINE at column 40 -> after release, the sweep restarts at address 0 and the cursor is (0,0).

Source files
------------

// File: rtl/text_pkg.sv
// Shared constants, types and helpers for the text console controller.
package text_pkg;

  localparam int unsigned COLS_DEF = 80;
  localparam int unsigned ROWS_DEF = 60;
  localparam int unsigned ROW_W    = 6;
  localparam int unsigned COL_W    = 7;
  localparam int unsigned CH_W     = 7;
  localparam int unsigned ADDR_W   = ROW_W + COL_W;

  localparam logic [CH_W-1:0] BLANK_DEF = 7'h20;
  localparam logic [CH_W-1:0] CODE_BS   = 7'h08;
  localparam logic [CH_W-1:0] CODE_CR   = 7'h0D;

  typedef enum logic [1:0] {CLEAR, IDLE, WRITE, CLRLINE} state_t;

  typedef enum logic [2:0] {CUR_HOLD, CUR_INC, CUR_DEC, CUR_NL, CUR_HOME} cur_op_t;

  // Character RAM cell address, laid out as {row,col}.
  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } cell_t;

  function automatic logic is_printable(input logic [CH_W-1:0] c);
    return (c >= 7'h20) && (c <= 7'h7E);
  endfunction

endpackage

// File: rtl/text_console_ctrl_if.sv
// Character input handshake, display read request and char RAM port bundle.
interface text_console_ctrl_if;
  import text_pkg::*;

  logic              ch_valid;
  logic [CH_W-1:0]   ch_data;
  logic              ch_ready;
  logic              vga_req;
  logic [ROW_W-1:0]  vga_row;
  logic [COL_W-1:0]  vga_col;
  logic [ADDR_W-1:0] cram_a;
  logic [CH_W-1:0]   cram_di;
  logic              cram_we;

  modport slave (
    input  ch_valid, ch_data, vga_req, vga_row, vga_col,
    output ch_ready, cram_a, cram_di, cram_we
  );

  modport master (
    output ch_valid, ch_data, vga_req, vga_row, vga_col,
    input  ch_ready, cram_a, cram_di, cram_we
  );

endinterface

// File: rtl/text_cursor.sv
// Cursor row/column register with increment-wrap, decrement and newline.
module text_cursor
  import text_pkg::*;
#(
  parameter int unsigned COLS = COLS_DEF,
  parameter int unsigned ROWS = ROWS_DEF
) (
  input  logic    clk,
  input  logic    clr,
  input  cur_op_t op,
  output cell_t   pos,
  output cell_t   dec_pos_c,
  output logic    inc_wrap_c
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  logic [ROW_W-1:0] row_adv;
  cell_t            pos_nxt;

  assign row_adv    = (pos.row == ROW_LAST) ? '0 : pos.row + ROW_W'(1);
  assign inc_wrap_c = (pos.col == COL_LAST);

  // Backspace target: previous column, or last column of the previous row.
  always_comb begin
    dec_pos_c = pos;
    if (pos.col != '0) begin
      dec_pos_c.col = pos.col - COL_W'(1);
    end else begin
      dec_pos_c.row = (pos.row == '0) ? ROW_LAST : pos.row - ROW_W'(1);
      dec_pos_c.col = COL_LAST;
    end
  end

  always_comb begin
    pos_nxt = pos;
    unique case (op)
      CUR_INC: begin
        if (inc_wrap_c) begin
          pos_nxt.row = row_adv;
          pos_nxt.col = '0;
        end else begin
          pos_nxt.col = pos.col + COL_W'(1);
        end
      end
      CUR_DEC:  pos_nxt = dec_pos_c;
      CUR_NL: begin
        pos_nxt.row = row_adv;
        pos_nxt.col = '0;
      end
      CUR_HOME: pos_nxt = '0;
      default:  pos_nxt = pos;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) pos <= '0;
    else     pos <= pos_nxt;
  end

endmodule

// File: rtl/text_console_ctrl.sv
// Text console controller: screen clear, character/control handling and
// char RAM port sharing with the display reader (display always wins).
module text_console_ctrl
  import text_pkg::*;
#(
  parameter int unsigned      COLS  = COLS_DEF,
  parameter int unsigned      ROWS  = ROWS_DEF,
  parameter logic [CH_W-1:0]  BLANK = BLANK_DEF
) (
  input  logic                clk,
  input  logic                clr,
  text_console_ctrl_if.slave  bus,
  output logic [ROW_W-1:0]    cur_row,
  output logic [COL_W-1:0]    cur_col,
  output logic                busy
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  state_t          state, state_nxt;
  cell_t           sweep, sweep_nxt;
  logic [CH_W-1:0] wdata, wdata_nxt;
  logic            wr_bs, wr_bs_nxt;
  cur_op_t         cur_op;
  cell_t           pos, dec_pos, ctl_a;
  logic            inc_wrap, ctl_we, stall;
  logic [CH_W-1:0] ctl_di;

  text_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .clk        (clk),
    .clr        (clr),
    .op         (cur_op),
    .pos        (pos),
    .dec_pos_c  (dec_pos),
    .inc_wrap_c (inc_wrap)
  );

  assign stall   = bus.vga_req;
  assign cur_row = pos.row;
  assign cur_col = pos.col;

  // Display reader owns the port whenever it asks for it.
  assign bus.cram_a  = stall ? {bus.vga_row, bus.vga_col} : ctl_a;
  assign bus.cram_we = ctl_we && !stall && !clr;
  assign bus.cram_di = ctl_di;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state        <= CLEAR;
      sweep        <= '0;
      wdata        <= BLANK;
      wr_bs        <= 1'b0;
      busy         <= 1'b1;
      bus.ch_ready <= 1'b0;
    end else begin
      state        <= state_nxt;
      sweep        <= sweep_nxt;
      wdata        <= wdata_nxt;
      wr_bs        <= wr_bs_nxt;
      busy         <= (state_nxt != IDLE);
      bus.ch_ready <= (state_nxt == IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    sweep_nxt = sweep;
    wdata_nxt = wdata;
    wr_bs_nxt = wr_bs;
    cur_op    = CUR_HOLD;
    ctl_we    = 1'b0;
    ctl_a     = sweep;
    ctl_di    = BLANK;
    case (state)
      CLEAR: begin
        ctl_we = 1'b1;
        if (!stall) begin
          if (sweep.col == COL_LAST) begin
            sweep_nxt.col = '0;
            if (sweep.row == ROW_LAST) begin
              sweep_nxt.row = '0;
              cur_op        = CUR_HOME;
              state_nxt     = IDLE;
            end else begin
              sweep_nxt.row = sweep.row + ROW_W'(1);
            end
          end else begin
            sweep_nxt.col = sweep.col + COL_W'(1);
          end
        end
      end
      IDLE: begin
        if (bus.ch_valid) begin
          if (is_printable(bus.ch_data)) begin
            wdata_nxt = bus.ch_data;
            wr_bs_nxt = 1'b0;
            state_nxt = WRITE;
          end else if (bus.ch_data == CODE_CR) begin
            cur_op    = CUR_NL;
            sweep_nxt = '0;
            state_nxt = CLRLINE;
          end else if (bus.ch_data == CODE_BS && pos != '0) begin
            wdata_nxt = BLANK;
            wr_bs_nxt = 1'b1;
            state_nxt = WRITE;
          end
        end
      end
      // Cursor only moves on the edge that lands the write.
      WRITE: begin
        ctl_we = 1'b1;
        ctl_a  = wr_bs ? dec_pos : pos;
        ctl_di = wdata;
        if (!stall) begin
          if (wr_bs) begin
            cur_op    = CUR_DEC;
            state_nxt = IDLE;
          end else begin
            cur_op = CUR_INC;
            if (inc_wrap) begin
              sweep_nxt = '0;
              state_nxt = CLRLINE;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      CLRLINE: begin
        ctl_we    = 1'b1;
        ctl_a.row = pos.row;
        ctl_a.col = sweep.col;
        if (!stall) begin
          if (sweep.col == COL_LAST) begin
            sweep_nxt = '0;
            state_nxt = IDLE;
          end else begin
            sweep_nxt.col = sweep.col + COL_W'(1);
          end
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Self-checking bench for text_console_ctrl: vector table, directed corner
// sequences and random traffic against a screen/cursor reference model.
module tb_text_console_ctrl;

  localparam int         COLS = 80;
  localparam int         ROWS = 60;
  localparam logic [6:0] BL   = 7'h20;

  typedef struct packed { logic [12:0] a; logic [6:0] d; } wr_t;
  typedef struct {
    logic [6:0] code; int stall; int er; int ec; int nwr; int wr; int wc; logic [6:0] wd;
  } vec_t;

  logic       clk = 1'b0;
  logic       clr;
  logic [5:0] cur_row;
  logic [6:0] cur_col;
  logic       busy;

  text_console_ctrl_if bus ();

  text_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .BLANK(BL)) dut (
    .clk     (clk),
    .clr     (clr),
    .bus     (bus),
    .cur_row (cur_row),
    .cur_col (cur_col),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Char RAM stand-in plus a log of every write that lands.
  logic [6:0] ram [0:8191];
  wr_t        wlog [$];
  always @(posedge clk) begin
    if (bus.cram_we === 1'b1) begin
      ram[bus.cram_a] <= bus.cram_di;
      wlog.push_back({bus.cram_a, bus.cram_di});
    end
  end

  int n_cmp = 0, n_fail = 0, arb_err = 0, hold_err = 0, first_we = -1;

  // Reference model: cursor, expected screen, expected writes of one command.
  int         mr, mc;
  logic [6:0] scr [ROWS][COLS];
  wr_t        exp_q [$];

  function automatic wr_t mk(input int r, input int c, input logic [6:0] d);
    wr_t w;
    w.a = 13'((r << 7) | c);
    w.d = d;
    return w;
  endfunction

  function automatic void put(input int r, input int c, input logic [6:0] d);
    scr[r][c] = d;
    exp_q.push_back(mk(r, c, d));
  endfunction

  function automatic void model_reset();
    mr = 0; mc = 0;
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) scr[r][c] = BL;
  endfunction

  function automatic void model_apply(input logic [6:0] code);
    exp_q.delete();
    if (code >= 7'h20 && code <= 7'h7E) begin
      put(mr, mc, code);
      mc++;
      if (mc == COLS) begin
        mc = 0; mr = (mr + 1) % ROWS;
        for (int c = 0; c < COLS; c++) put(mr, c, BL);
      end
    end else if (code == 7'h0D) begin
      mc = 0; mr = (mr + 1) % ROWS;
      for (int c = 0; c < COLS; c++) put(mr, c, BL);
    end else if (code == 7'h08) begin
      if (mc > 0) begin
        mc--; put(mr, mc, BL);
      end else if (mr > 0) begin
        mr--; mc = COLS - 1; put(mr, mc, BL);
      end
    end
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle(input string nm, input int bound);
    int n = 0;
    while (busy !== 1'b0 && n < bound) begin cyc(); n++; end
    check(nm, 32'(busy), 0);
  endtask

  task automatic check_screen(input string nm);
    int bad = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (ram[(r << 7) | c] !== scr[r][c]) bad++;
    check(nm, bad, 0);
  endtask

  // Offer one code, hold vga_req for stall_n cycles (then random if rnd),
  // run to IDLE and compare writes and cursor with the model.
  task automatic send(input logic [6:0] code, input int stall_n, input bit rnd);
    int         n, bad;
    logic [5:0] r0;
    logic [6:0] c0;
    wlog.delete();
    first_we = -1;
    n = 0;
    while (bus.ch_ready !== 1'b1 && n < 10000) begin cyc(); n++; end
    check("ready_before_send", 32'(bus.ch_ready), 1);
    r0 = cur_row; c0 = cur_col;
    bus.ch_valid = 1'b1; bus.ch_data = code; bus.vga_req = 1'b0;
    cyc();
    bus.ch_valid = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      bus.vga_req = (n < stall_n) ? 1'b1 : (rnd ? ($urandom_range(0, 3) == 0) : 1'b0);
      bus.vga_row = 6'($urandom);
      bus.vga_col = 7'($urandom);
      #1;
      if (bus.vga_req && (bus.cram_we !== 1'b0 || bus.cram_a !== {bus.vga_row, bus.vga_col}))
        arb_err++;
      if (first_we < 0 && code != 7'h0D && (cur_row !== r0 || cur_col !== c0)) hold_err++;
      if (bus.cram_we === 1'b1 && first_we < 0) first_we = n;
      cyc();
      n++;
    end
    bus.vga_req = 1'b0;
    check("send_done", 32'(busy), 0);
    model_apply(code);
    check("send_wr_count", wlog.size(), exp_q.size());
    bad = 0;
    for (int i = 0; i < wlog.size() && i < exp_q.size(); i++) if (wlog[i] !== exp_q[i]) bad++;
    check("send_wr_content", bad, 0);
    check("send_cur_row", 32'(cur_row), mr);
    check("send_cur_col", 32'(cur_col), mc);
  endtask

  task automatic goto_pos(input int r, input int c);
    if (!(mr == r && mc <= c)) begin
      if (mc != 0) send(7'h0D, 0, 1'b0);
      while (mr != r) send(7'h0D, 0, 1'b0);
    end
    while (mc < c) send(7'(97 + mc % 26), 0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t       vt [10];
    wr_t        w0;
    int         bad, bad2, r_new;
    logic [6:0] code;

    vt[0] = '{7'h43, 0, 0, 2,  1, 0, 1,  7'h43};
    vt[1] = '{7'h08, 2, 0, 1,  1, 0, 1,  7'h20};
    vt[2] = '{7'h07, 0, 0, 1,  0, 0, 0,  7'h00};
    vt[3] = '{7'h7F, 1, 0, 1,  0, 0, 0,  7'h00};
    vt[4] = '{7'h7E, 3, 0, 2,  1, 0, 1,  7'h7E};
    vt[5] = '{7'h20, 0, 0, 3,  1, 0, 2,  7'h20};
    vt[6] = '{7'h0D, 1, 1, 0, 80, 1, 0,  7'h20};
    vt[7] = '{7'h08, 1, 0, 79, 1, 0, 79, 7'h20};
    vt[8] = '{7'h0D, 0, 1, 0, 80, 1, 0,  7'h20};
    vt[9] = '{7'h1B, 0, 1, 0,  0, 0, 0,  7'h00};

    clr = 1'b1;
    bus.ch_valid = 1'b0; bus.ch_data = 7'h00;
    bus.vga_req = 1'b0; bus.vga_row = '0; bus.vga_col = '0;
    @(negedge clk);
    cyc(); cyc();
    #1;
    check("rst_busy", 32'(busy), 1);
    check("rst_ready", 32'(bus.ch_ready), 0);
    check("rst_we", 32'(bus.cram_we), 0);
    check("rst_addr", 32'(bus.cram_a), 0);
    check("rst_cur", {cur_row, cur_col}, 0);
    cyc();

    // Full-screen sweep after reset release.
    wlog.delete();
    clr = 1'b0;
    wait_idle("clear_done", 6000);
    check("clear_count", wlog.size(), ROWS * COLS);
    bad = 0;
    for (int i = 0; i < wlog.size(); i++) if (wlog[i] !== mk(i / COLS, i % COLS, BL)) bad++;
    check("clear_order", bad, 0);
    w0 = (wlog.size() > 0) ? wlog[$] : '0;
    check("clear_last", w0, mk(59, 79, BL));
    check("clear_ready", 32'(bus.ch_ready), 1);
    check("clear_cur", {cur_row, cur_col}, 0);
    model_reset();

    // Backspace at home does nothing.
    send(7'h08, 0, 1'b0);
    check("bs_home_nowr", wlog.size(), 0);
    check("bs_home_cur", {cur_row, cur_col}, 0);

    // 'A' with display holding the port for two cycles.
    send(7'h41, 2, 1'b0);
    check("a_first_we_cycle", first_we, 2);
    check("a_wr_count", wlog.size(), 1);
    check("a_cell", 32'(ram[0]), 32'h41);
    check("a_cur", {cur_row, cur_col}, {6'd0, 7'd1});

    for (int i = 0; i < 10; i++) begin
      send(vt[i].code, vt[i].stall, 1'b0);
      check($sformatf("vec%0d_row", i), 32'(cur_row), vt[i].er);
      check($sformatf("vec%0d_col", i), 32'(cur_col), vt[i].ec);
      check($sformatf("vec%0d_nwr", i), wlog.size(), vt[i].nwr);
      if (vt[i].nwr > 0) begin
        w0 = (wlog.size() > 0) ? wlog[0] : '1;
        check($sformatf("vec%0d_first_wr", i), w0, mk(vt[i].wr, vt[i].wc, vt[i].wd));
        check($sformatf("vec%0d_first_cyc", i), first_we, vt[i].stall);
      end
    end

    // Printable at the last column wraps and blanks the next row.
    goto_pos(5, 79);
    send(7'h42, 0, 1'b0);
    check("wrap_count", wlog.size(), 81);
    w0 = (wlog.size() > 0) ? wlog[0] : '1;
    check("wrap_cell", w0, mk(5, 79, 7'h42));
    bad = 0;
    for (int i = 1; i < wlog.size(); i++) if (wlog[i] !== mk(6, i - 1, BL)) bad++;
    check("wrap_row6_blank", bad, 0);
    check("wrap_cur", {cur_row, cur_col}, {6'd6, 7'd0});

    // Carriage return on the last row wraps to row 0.
    goto_pos(59, 10);
    send(7'h0D, 0, 1'b0);
    check("cr_cur", {cur_row, cur_col}, 0);
    check("cr_count", wlog.size(), 80);
    bad = 0; bad2 = 0;
    for (int i = 0; i < wlog.size(); i++) begin
      if (wlog[i].a[12:7] != 6'd0 || wlog[i].d != BL) bad++;
      if (wlog[i].a == 13'((59 << 7) | 10)) bad2++;
    end
    check("cr_row0_blank", bad, 0);
    check("cr_no_old_write", bad2, 0);

    // Backspace from column 0 goes to the previous row's last column.
    goto_pos(3, 0);
    send(7'h08, 0, 1'b0);
    check("bs_wrap_cur", {cur_row, cur_col}, {6'd2, 7'd79});
    check("bs_wrap_count", wlog.size(), 1);
    check("bs_wrap_cell", 32'(ram[(2 << 7) | 79]), 32'h20);

    // Random traffic with random display contention.
    for (int i = 0; i < 250; i++) begin
      int p = $urandom_range(0, 99);
      if (p < 70)      code = 7'($urandom_range(32, 126));
      else if (p < 75) code = 7'h0D;
      else if (p < 92) code = 7'h08;
      else begin
        code = 7'($urandom_range(0, 31));
        if (code == 7'h08 || code == 7'h0D) code = 7'h7F;
      end
      send(code, $urandom_range(0, 2), 1'b1);
    end
    check_screen("screen_after_random");
    check("arbitration", arb_err, 0);
    check("cursor_hold_while_stalled", hold_err, 0);

    // Reset in the middle of a line clear restarts the full sweep.
    r_new = (mr + 1) % ROWS;
    bus.ch_valid = 1'b1; bus.ch_data = 7'h0D; bus.vga_req = 1'b0;
    cyc();
    bus.ch_valid = 1'b0;
    repeat (40) cyc();
    #1;
    check("abort_at_col40", 32'(bus.cram_a), (r_new << 7) | 40);
    check("abort_we_before", 32'(bus.cram_we), 1);
    clr = 1'b1;
    #1;
    check("abort_cur", {cur_row, cur_col}, 0);
    check("abort_busy", 32'(busy), 1);
    check("abort_ready", 32'(bus.ch_ready), 0);
    check("abort_we", 32'(bus.cram_we), 0);
    cyc(); cyc();
    wlog.delete();
    clr = 1'b0;
    #1;
    check("restart_addr", 32'(bus.cram_a), 0);
    check("restart_we", 32'(bus.cram_we), 1);
    wait_idle("reclear_done", 6000);
    check("reclear_count", wlog.size(), ROWS * COLS);
    w0 = (wlog.size() > 0) ? wlog[0] : '1;
    check("reclear_first", w0, mk(0, 0, BL));
    check("reclear_cur", {cur_row, cur_col}, 0);
    model_reset();
    check_screen("screen_after_reclear");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
